inagu_seq: RTL

- Job sequencer and control-delay stage that sits directly upstream of the input/weight address generator.
- On a start pulse it clears the address generator, then drives its enable for exactly `countdown` un-stalled cycles.
- It also samples the generator's per-cycle side signals (msb flags, shift, jump events). It delays them by the memory read latency so they arrive aligned with the read data at the downstream shift-accumulator.
- It signals job completion once the read pipeline has drained.

---
 rtl/inagu_seq_if.sv | 40 ++++
 rtl/inagu_seq.sv | 129 ++++++++++++
 2 files changed

// File: rtl/inagu_seq_if.sv
// Job-control and generator side-signal bundle between the job issuer,
// the input/weight address generator and the inagu_seq sequencer.
interface inagu_seq_if #(
  parameter int BCNT   = 16,
  parameter int NJUMPS = 5
);
  // Job issue and generator side signals (into the sequencer)
  logic              start;
  logic [BCNT-1:0]   countdown;
  logic              stall;
  logic [NJUMPS-1:0] acc_sel;
  logic              imsb_in;
  logic              wmsb_in;
  logic              sh_in;
  logic [NJUMPS-1:0] on_j_in;

  // Generator control and read-aligned side signals (out of the sequencer)
  logic              agu_clr;
  logic              agu_en;
  logic              busy;
  logic              done;
  logic              rd_valid;
  logic              imsb_d;
  logic              wmsb_d;
  logic              sh_d;
  logic              acc_end_d;
  logic              last_d;

  modport master (
    output start, countdown, stall, acc_sel, imsb_in, wmsb_in, sh_in, on_j_in,
    input  agu_clr, agu_en, busy, done, rd_valid, imsb_d, wmsb_d, sh_d,
           acc_end_d, last_d
  );

  modport slave (
    input  start, countdown, stall, acc_sel, imsb_in, wmsb_in, sh_in, on_j_in,
    output agu_clr, agu_en, busy, done, rd_valid, imsb_d, wmsb_d, sh_d,
           acc_end_d, last_d
  );
endinterface

// File: rtl/inagu_seq.sv
// Job sequencer and control-delay stage in front of the input/weight address
// generator. Clears the generator, enables it for `countdown` un-stalled
// cycles, and delays the generator's side signals by the memory read latency
// so they line up with read data at the shift-accumulator.
module inagu_seq #(
  parameter int BCNT   = 16,
  parameter int MEMLAT = 2,   // memory read latency, 1..8
  parameter int NJUMPS = 5
) (
  input  logic        clk,
  input  logic        clr,
  inagu_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DRAIN} state_t;

  // One entry of the read-latency delay line; all fields are zero when v=0
  typedef struct packed {
    logic v;
    logic imsb;
    logic wmsb;
    logic sh;
    logic acc;
    logic last;
  } rd_tag_t;

  localparam logic [3:0] DRAIN_INIT = 4'(MEMLAT - 1);

  state_t          state_q;
  logic [BCNT-1:0] cnt_q;
  logic [3:0]      dcnt_q;
  logic            done_q;
  rd_tag_t         pipe_q [MEMLAT];

  logic            en;
  logic            final_elem;
  rd_tag_t         entry;

  // Stall only matters in RUN; a reset cycle never steps the generator
  assign en         = (state_q == RUN) && !bus.stall && !clr;
  assign final_elem = en && (cnt_q == BCNT'(1));

  // Build the delay-line entry for this cycle's generator step
  always_comb begin
    // NOTE: every field gets a default before the conditional terms so no
    // latch can be inferred if a term is later made conditional.
    entry      = '0;
    entry.v    = en;
    entry.imsb = en && bus.imsb_in;
    entry.wmsb = en && bus.wmsb_in;
    entry.sh   = en && bus.sh_in;
    // The final element always closes the running accumulation
    entry.acc  = en && ((|(bus.acc_sel & bus.on_j_in)) || final_elem);
    entry.last = final_elem;
  end

  // Job FSM: counts enabled cycles, then waits for the read pipeline to drain
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.countdown != '0) begin
              cnt_q   <= bus.countdown;
              state_q <= CLEAR;
            end else begin
              // Empty job: acknowledge immediately without touching the AGU
              done_q <= 1'b1;
            end
          end
        end
        CLEAR: state_q <= RUN;
        RUN: begin
          if (en) begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == BCNT'(1)) begin
              state_q <= DRAIN;
              dcnt_q  <= DRAIN_INIT;
              // With a one-deep pipe the final read lands in the first DRAIN cycle
              if (DRAIN_INIT == 4'd0) done_q <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (dcnt_q == 4'd0) begin
            state_q <= IDLE;
          end else begin
            dcnt_q <= dcnt_q - 4'd1;
            // done is registered, so raise it one cycle ahead of the last read
            if (dcnt_q == 4'd1) done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read-latency delay line; advances every cycle, independent of stall
  always_ff @(posedge clk) begin
    if (clr) begin
      // NOTE: this small delay line is reset on purpose so an aborted job
      // leaves no stale rd_valid behind; large data memories would not be.
      for (int i = 0; i < MEMLAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= entry;
      for (int i = 1; i < MEMLAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign bus.agu_clr   = clr || (state_q == CLEAR);
  assign bus.agu_en    = en;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.rd_valid  = pipe_q[MEMLAT-1].v;
  assign bus.imsb_d    = pipe_q[MEMLAT-1].imsb;
  assign bus.wmsb_d    = pipe_q[MEMLAT-1].wmsb;
  assign bus.sh_d      = pipe_q[MEMLAT-1].sh;
  assign bus.acc_end_d = pipe_q[MEMLAT-1].acc;
  assign bus.last_d    = pipe_q[MEMLAT-1].last;

endmodule
